// File: rtl/cmp_pkg.sv
// Shared definitions for the sliced magnitude-compare sequencer.
//   state_t     : controller FSM states
//   nslice()    : number of comparator slices covering an operand
//   RES_*       : {eq,lt,gt} result encodings
package cmp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

endpackage

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit unsigned comparator.
//   a, b       : slice operands
//   eq, lt, gt : one-hot relation of a to b
module cmp_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    assign eq = (a == b);
    assign lt = (a <  b);
    assign gt = (a >  b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// WIDTH-bit unsigned magnitude compare sequenced over one shared SLICE-bit
// comparator, most-significant slice first, stopping at the first unequal slice.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request a compare (accepted only while ready)
//   abort       : cancel an in-flight compare, no done
//   a, b        : operands, captured on accepted start
//   ready, busy : idle / compare in progress
//   done        : one-cycle pulse when eq/lt/gt/slices_used are updated
//   eq, lt, gt  : registered one-hot result, held until the next done
//   slices_used : slices examined for the last result
module cmp_seq_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic                                     abort,
    input  logic [WIDTH-1:0]                         a,
    input  logic [WIDTH-1:0]                         b,
    output logic                                     ready,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     eq,
    output logic                                     lt,
    output logic                                     gt,
    output logic [$clog2(nslice(WIDTH, SLICE)):0]    slices_used
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int CNTW   = $clog2(NSLICE) + 1;

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("cmp_seq_ctrl: WIDTH must be a multiple of SLICE");
    end

    state_t            state, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [IDXW-1:0]   idx;
    logic [SLICE-1:0]  sa, sb;
    logic              s_eq, s_lt, s_gt;
    logic              load, step, finish;
    logic [2:0]        res_d;
    logic [CNTW-1:0]   used_d;

    // Slice mux over the captured operands.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) begin
                sa = a_q[i*SLICE +: SLICE];
                sb = b_q[i*SLICE +: SLICE];
            end
        end
    end

    cmp_slice #(.SLICE(SLICE)) u_slice (
        .a  (sa),
        .b  (sb),
        .eq (s_eq),
        .lt (s_lt),
        .gt (s_gt)
    );

    always_comb begin
        state_d = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        res_d   = s_eq ? RES_EQ : (s_lt ? RES_LT : (s_gt ? RES_GT : RES_NONE));
        used_d  = CNTW'(NSLICE) - CNTW'(idx);
        case (state)
            ST_IDLE: begin
                // abort together with start in IDLE suppresses the start
                if (start && !abort) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort takes priority over a result resolving this cycle
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!s_eq || idx == '0) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            idx          <= '0;
            done         <= 1'b0;
            {eq, lt, gt} <= RES_NONE;
            slices_used  <= '0;
        end else begin
            done <= finish;
            if (load) begin
                a_q <= a;
                b_q <= b;
                idx <= IDXW'(NSLICE - 1);
            end else if (step) begin
                idx <= idx - 1'b1;
            end
            if (finish) begin
                {eq, lt, gt} <= res_d;
                slices_used  <= used_d;
            end
        end
    end

    assign busy  = (state == ST_RUN);
    assign ready = !busy;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
module tb_cmp_seq_ctrl;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort;
    logic [WIDTH-1:0]  a, b;
    logic              ready, busy, done, eq, lt, gt;
    logic [2:0]        slices_used;

    int checks = 0;
    int errors = 0;

    cmp_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt),
        .slices_used (slices_used)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: full-width compare; slices examined = slices down to and
    // including the one holding the highest differing bit.
    function automatic void ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    output int m, output logic [2:0] r);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        m = NSLICE;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (d[i]) begin
                m = NSLICE - i / SLICE;
                break;
            end
        end
        r = (x == y) ? EQ : ((x < y) ? LT : GT);
    endfunction

    // Behavioural model: a busy flag with a countdown of remaining cycles.
    bit         m_busy, m_done;
    int         m_left, m_pend_m, m_used;
    logic [2:0] m_pend_r, m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_left = 0;
            m_used = 0; m_res = 3'b000;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (abort) begin
                    m_busy = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_done = 1;
                        m_res  = m_pend_r;
                        m_used = m_pend_m;
                    end
                end
            end else if (start && !abort) begin
                ref_cmp(a, b, m_pend_m, m_pend_r);
                m_left = m_pend_m;
                m_busy = 1;
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",        32'(busy),        32'(m_busy));
            chk("ready",       32'(ready),       32'(!m_busy));
            chk("done",        32'(done),        32'(m_done));
            chk("result",      32'({eq, lt, gt}), 32'(m_res));
            chk("slices_used", 32'(slices_used), 32'(m_used));
        end
    end

    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called #1 after the accepting edge E0; expects done #1 after edge E_exp_m.
    task automatic wait_done(input string nm, input int exp_m, input logic [2:0] exp_r,
                             input bit busy_starts);
        bit seen = 0;
        start = busy_starts;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = busy_starts && (k < 2);
            if (done) begin
                chk({nm, "_latency"}, 32'(k), 32'(exp_m));
                chk({nm, "_result"},  32'({eq, lt, gt}), 32'(exp_r));
                chk({nm, "_used"},    32'(slices_used), 32'(exp_m));
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) chk({nm, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic quiet(input string nm, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk({nm, "_no_done"}, 32'(done), 32'(0));
        end
    endtask

    initial begin
        int         pm;
        logic [2:0] pr;
        logic [WIDTH-1:0] ra;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;

        // Pin the reference model itself.
        ref_cmp(16'h1234, 16'h1234, pm, pr); chk("ref_eq", 32'({pm, pr}), 32'({32'd4, EQ}));
        ref_cmp(16'h9000, 16'h1FFF, pm, pr); chk("ref_gt", 32'({pm, pr}), 32'({32'd1, GT}));
        ref_cmp(16'h12F4, 16'h12F5, pm, pr); chk("ref_lt", 32'({pm, pr}), 32'({32'd4, LT}));
        ref_cmp(16'h1240, 16'h1250, pm, pr); chk("ref_m3", 32'({pm, pr}), 32'({32'd3, LT}));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy),  32'(0));
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_done",  32'(done),  32'(0));
        chk("rst_res",   32'({eq, lt, gt}), 32'(0));
        chk("rst_used",  32'(slices_used), 32'(0));
        rst_n  = 1'b1;
        cmp_en = 1;

        launch(16'h1234, 16'h1234); wait_done("eq1234", 4, EQ, 0);
        launch(16'h9000, 16'h1FFF); wait_done("gt9000", 1, GT, 0);
        launch(16'h12F4, 16'h12F5); wait_done("lt12F4", 4, LT, 0);
        launch(16'h0000, 16'h0000); wait_done("busy_start", 4, EQ, 1);
        quiet("busy_start", 3);

        // Back-to-back: second start issued in the done cycle.
        launch(16'h1230, 16'h1231); wait_done("b2b_first", 4, LT, 0);
        launch(16'hF000, 16'h0000); wait_done("b2b_second", 1, GT, 0);

        // Abort sampled at E3: no done, previous GT/1 held.
        launch(16'hABCD, 16'hABCD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_res",  32'({eq, lt, gt}), 32'(GT));
        chk("abort_used", 32'(slices_used), 32'(1));
        quiet("abort", 4);

        // Asynchronous reset mid-compare.
        launch(16'h5555, 16'h5555);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy),  32'(0));
        chk("arst_done", 32'(done),  32'(0));
        chk("arst_res",  32'({eq, lt, gt}), 32'(0));
        chk("arst_used", 32'(slices_used), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet("arst", 6);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            ra = WIDTH'($urandom);
            a  = ra;
            case ($urandom_range(0, 3))
                0: b = ra;
                1: b = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                2: b = WIDTH'($urandom);
                default: b = ra ^ (WIDTH'($urandom_range(1, 15)) << (SLICE * $urandom_range(0, NSLICE - 1)));
            endcase
            start = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 11) == 0);
        end
        start = 1'b0; abort = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
